// File: rtl/md_defs.sv
// Shared op encoding, latencies and FSM state type for the E-stage multiply/divide unit.
package md_defs;
    localparam int unsigned MD_OP_W   = 4;
    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_CNT_W  = 8;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that need a start pulse and a busy window.
    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction
endpackage

// File: rtl/E_MDU_calc.sv
// Combinational multiply/divide datapath: captured operands + op -> {hi, lo} and a divide-by-zero flag.
module E_MDU_calc
    import md_defs::*;
(
    input  logic [MD_OP_W-1:0]     op,
    input  logic [MD_DATA_W-1:0]   a,
    input  logic [MD_DATA_W-1:0]   b,
    output logic [2*MD_DATA_W-1:0] result,
    output logic                   div_zero
);
    logic signed [2*MD_DATA_W-1:0] w_sa, w_sb;
    logic        [MD_DATA_W-1:0]   w_b_safe, w_ma, w_mb, w_qm, w_rm;

    assign w_sa     = {{MD_DATA_W{a[MD_DATA_W-1]}}, a};
    assign w_sb     = {{MD_DATA_W{b[MD_DATA_W-1]}}, b};
    assign w_b_safe = (b == '0) ? MD_DATA_W'(1) : b;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no overflow special case.
    assign w_ma = a[MD_DATA_W-1] ? MD_DATA_W'(-a) : a;
    assign w_mb = w_b_safe[MD_DATA_W-1] ? MD_DATA_W'(-w_b_safe) : w_b_safe;
    assign w_qm = w_ma / w_mb;
    assign w_rm = w_ma % w_mb;

    always_comb begin
        result   = '0;
        div_zero = md_is_div(op) && (b == '0);
        case (op)
            MD_MULT:  result = 64'(w_sa * w_sb);
            MD_MULTU: result = 64'({32'd0, a} * {32'd0, b});
            MD_DIV: begin
                result[2*MD_DATA_W-1:MD_DATA_W] = a[MD_DATA_W-1] ? MD_DATA_W'(-w_rm) : w_rm;
                result[MD_DATA_W-1:0] = (a[MD_DATA_W-1] ^ b[MD_DATA_W-1]) ? MD_DATA_W'(-w_qm) : w_qm;
            end
            MD_DIVU:  result = {a % w_b_safe, a / w_b_safe};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/e_mdu.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO, MTHI/MTLO writes and MFHI/MFLO reads.
module e_mdu
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic        E_start,
    input  logic [31:0] E_data1,
    input  logic [31:0] E_data2,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_md_out
);
    md_state_e                r_state;
    logic [MD_CNT_W-1:0]      r_cnt;
    logic [MD_OP_W-1:0]       r_op;
    logic [MD_DATA_W-1:0]     r_a, r_b, r_hi, r_lo;
    logic                     r_busy;
    logic [2*MD_DATA_W-1:0]   w_result;
    logic                     w_div_zero;

    E_MDU_calc u_calc (
        .op       (r_op),
        .a        (r_a),
        .b        (r_b),
        .result   (w_result),
        .div_zero (w_div_zero)
    );

    // Commit happens on the edge where the counter reads 1; a zero divisor skips the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (E_start && md_is_arith(E_md_op)) begin
                        r_op    <= E_md_op;
                        r_a     <= E_data1;
                        r_b     <= E_data2;
                        r_cnt   <= md_is_div(E_md_op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else if (E_md_op == MD_MTHI) begin
                        r_hi <= E_data1;
                    end else if (E_md_op == MD_MTLO) begin
                        r_lo <= E_data1;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == MD_CNT_W'(1)) begin
                        if (!w_div_zero) begin
                            r_hi <= w_result[2*MD_DATA_W-1:MD_DATA_W];
                            r_lo <= w_result[MD_DATA_W-1:0];
                        end
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        E_md_out = '0;
        if (E_md_op == MD_MFHI)      E_md_out = r_hi;
        else if (E_md_op == MD_MFLO) E_md_out = r_lo;
    end

    assign E_busy = r_busy;
    assign E_HI   = r_hi;
    assign E_LO   = r_lo;
endmodule
